// File: rtl/ddr_read_eye_centering.sv
// Per-bit read-eye training for one DQ lane: sweeps each IOD delay line, finds the
// first contiguous passing window from the eye-monitor flags and parks the tap at its centre.
module ddr_read_eye_centering #(
    parameter int NUM_BITS   = 8,
    parameter int TAP_W      = 7,
    parameter int MAX_TAP    = 127,
    parameter int SETTLE_CYC = 7,
    parameter int SAMPLE_CYC = 15,
    parameter int MIN_WINDOW = 4
) (
    input  logic                      fab_clk,
    input  logic                      arst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_BITS-1:0]       err_mask,
    output logic [NUM_BITS*TAP_W-1:0] tap_out,
    output logic [NUM_BITS-1:0]       delay_line_load,
    output logic [NUM_BITS-1:0]       delay_line_move,
    output logic [NUM_BITS-1:0]       delay_line_direction,
    input  logic [NUM_BITS-1:0]       delay_line_out_of_range,
    output logic [NUM_BITS-1:0]       eye_monitor_clear_flags,
    input  logic [NUM_BITS-1:0]       eye_monitor_early,
    input  logic [NUM_BITS-1:0]       eye_monitor_late,
    output logic [3:0]                state_dbg
);

    localparam int IDX_W   = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam int CNT_MAX = (SETTLE_CYC > SAMPLE_CYC) ? SETTLE_CYC : SAMPLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        LOAD   = 4'd1,
        SETTLE = 4'd2,
        CLEAR  = 4'd3,
        SAMPLE = 4'd4,
        EVAL   = 4'd5,
        STEP   = 4'd6,
        CENTER = 4'd7,
        NEXT   = 4'd8,
        FINISH = 4'd9
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [TAP_W-1:0] tap;
    logic [TAP_W-1:0] left_tap;
    logic [TAP_W-1:0] right_tap;
    logic             found;
    logic             stepped;
    logic             centering;
    logic [CNT_W-1:0] cnt;

    logic [NUM_BITS-1:0] idx_oh;
    logic [TAP_W:0]      win_sum;
    logic [TAP_W:0]      win_len;
    logic [TAP_W-1:0]    target;
    logic                window_ok;
    logic                pass;

    assign state_dbg = state;
    assign idx_oh    = NUM_BITS'(1) << idx;
    assign win_sum   = {1'b0, left_tap} + {1'b0, right_tap};
    assign target    = win_sum[TAP_W:1];
    assign win_len   = {1'b0, right_tap} - {1'b0, left_tap} + (TAP_W+1)'(1);
    assign window_ok = found && (win_len >= (TAP_W+1)'(MIN_WINDOW));
    assign pass      = !(eye_monitor_early[idx] | eye_monitor_late[idx]);

    // Pulse outputs are registered on the transition into the state that owns them,
    // so each one is high for exactly one cycle and only on the active bit.
    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            state                   <= IDLE;
            idx                     <= '0;
            tap                     <= '0;
            left_tap                <= '0;
            right_tap               <= '0;
            found                   <= 1'b0;
            stepped                 <= 1'b0;
            centering               <= 1'b0;
            cnt                     <= '0;
            busy                    <= 1'b0;
            done                    <= 1'b0;
            err_mask                <= '0;
            tap_out                 <= '0;
            delay_line_load         <= '0;
            delay_line_move         <= '0;
            delay_line_direction    <= '0;
            eye_monitor_clear_flags <= '0;
        end else begin
            delay_line_load         <= '0;
            delay_line_move         <= '0;
            eye_monitor_clear_flags <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        done            <= 1'b0;
                        err_mask        <= '0;
                        busy            <= 1'b1;
                        idx             <= '0;
                        delay_line_load <= NUM_BITS'(1);
                        state           <= LOAD;
                    end
                end
                LOAD: begin
                    tap       <= '0;
                    found     <= 1'b0;
                    stepped   <= 1'b0;
                    centering <= 1'b0;
                    cnt       <= '0;
                    state     <= SETTLE;
                end
                SETTLE: begin
                    if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                        cnt <= '0;
                        if (centering) begin
                            state <= CENTER;
                        end else if (stepped && delay_line_out_of_range[idx]) begin
                            // The line refused the last step: undo it and close the window here.
                            tap   <= tap - TAP_W'(1);
                            state <= CENTER;
                        end else begin
                            eye_monitor_clear_flags <= idx_oh;
                            state                   <= CLEAR;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CLEAR: begin
                    cnt   <= '0;
                    state <= SAMPLE;
                end
                SAMPLE: begin
                    if (cnt == CNT_W'(SAMPLE_CYC - 1)) begin
                        cnt   <= '0;
                        state <= EVAL;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                EVAL: begin
                    if (pass) begin
                        if (!found) begin
                            left_tap <= tap;
                            found    <= 1'b1;
                        end
                        right_tap <= tap;
                    end
                    if (!pass && found) begin
                        state <= CENTER;
                    end else if (tap == TAP_W'(MAX_TAP)) begin
                        state <= CENTER;
                    end else begin
                        delay_line_move           <= idx_oh;
                        delay_line_direction[idx] <= 1'b1;
                        state                     <= STEP;
                    end
                end
                STEP: begin
                    tap     <= tap + TAP_W'(1);
                    stepped <= 1'b1;
                    cnt     <= '0;
                    state   <= SETTLE;
                end
                CENTER: begin
                    if (!window_ok) begin
                        err_mask[idx]                <= 1'b1;
                        tap_out[idx*TAP_W +: TAP_W]  <= '0;
                        delay_line_load              <= idx_oh;
                        state                        <= NEXT;
                    end else if (tap == target) begin
                        tap_out[idx*TAP_W +: TAP_W]  <= target;
                        state                        <= NEXT;
                    end else begin
                        delay_line_move           <= idx_oh;
                        delay_line_direction[idx] <= 1'b0;
                        tap                       <= tap - TAP_W'(1);
                        centering                 <= 1'b1;
                        cnt                       <= '0;
                        state                     <= SETTLE;
                    end
                end
                NEXT: begin
                    if (idx == IDX_W'(NUM_BITS - 1)) begin
                        state <= FINISH;
                    end else begin
                        idx             <= idx + IDX_W'(1);
                        delay_line_load <= idx_oh << 1;
                        state           <= LOAD;
                    end
                end
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_read_eye_centering.sv
// Directed bench for ddr_read_eye_centering: behavioural IOD model per bit, expected
// results queued by the driver and checked by a monitor when DONE rises.
module tb_ddr_read_eye_centering;

    localparam int NB = 2;
    localparam int TW = 7;

    typedef struct packed {
        logic [7:0]     loads;
        logic [7:0]     dec0;
        logic [NB-1:0]  err;
        logic [NB*TW-1:0] tap;
    } exp_t;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy, done;
    logic [NB-1:0]     err_mask;
    logic [NB*TW-1:0]  tap_out;
    logic [NB-1:0]     ld, mv, dir, clr, oor;
    logic [NB-1:0]     early = '0;
    logic [NB-1:0]     late = '0;
    logic [3:0]        state_dbg;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    int iod_tap[NB] = '{0, 0};
    int win_lo[NB]  = '{1, 1};
    int win_hi[NB]  = '{0, 0};
    int oor_at[NB]  = '{127, 127};

    ddr_read_eye_centering #(
        .NUM_BITS(NB), .TAP_W(TW), .MAX_TAP(31),
        .SETTLE_CYC(2), .SAMPLE_CYC(3), .MIN_WINDOW(4)
    ) dut (
        .fab_clk(clk),
        .arst_n(arst_n),
        .start(start),
        .busy(busy),
        .done(done),
        .err_mask(err_mask),
        .tap_out(tap_out),
        .delay_line_load(ld),
        .delay_line_move(mv),
        .delay_line_direction(dir),
        .delay_line_out_of_range(oor),
        .eye_monitor_clear_flags(clr),
        .eye_monitor_early(early),
        .eye_monitor_late(late),
        .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // IOD model: delay-line tap tracking and sticky eye flags.
    assign oor[0] = (iod_tap[0] >= oor_at[0]);
    assign oor[1] = (iod_tap[1] >= oor_at[1]);

    always @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (ld[i]) iod_tap[i] <= 0;
            else if (mv[i]) iod_tap[i] <= dir[i] ? iod_tap[i] + 1 : iod_tap[i] - 1;
            if (clr[i]) begin
                early[i] <= 1'b0;
                late[i]  <= 1'b0;
            end else if (iod_tap[i] < win_lo[i]) begin
                early[i] <= 1'b1;
            end else if (iod_tap[i] > win_hi[i]) begin
                late[i] <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    int   cyc = 0;
    int   load_cnt = 0;
    int   dec0_cnt = 0;
    int   spacing_err = 0;
    int   onehot_err = 0;
    int   last_clr[NB] = '{-1, -1};
    logic done_q = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (start && !busy) begin
            load_cnt    = 0;
            dec0_cnt    = 0;
            spacing_err = 0;
            onehot_err  = 0;
            last_clr    = '{-1, -1};
        end
        if ($countones(ld) > 1 || $countones(mv) > 1 || $countones(clr) > 1) onehot_err++;
        load_cnt += $countones(ld);
        if (mv[0] && !dir[0]) dec0_cnt++;
        for (int i = 0; i < NB; i++) begin
            if (ld[i]) last_clr[i] = -1;
            if (clr[i]) begin
                if (last_clr[i] >= 0 && (cyc - last_clr[i]) != 8) spacing_err++;
                last_clr[i] = cyc;
            end
        end
        if (done && !done_q) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0");
            end else begin
                e = exp_q.pop_front();
                chk("err_mask", 32'(err_mask), 32'(e.err));
                chk("tap_out", 32'(tap_out), 32'(e.tap));
                chk("load_pulses", 32'(load_cnt), 32'(e.loads));
                chk("bit0_dec_moves", 32'(dec0_cnt), 32'(e.dec0));
                chk("clear_spacing_violations", 32'(spacing_err), 32'd0);
                chk("onehot_violations", 32'(onehot_err), 32'd0);
            end
        end
        done_q = done;
    end

    // Driver tasks
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_err_mask"}, 32'(err_mask), 32'd0);
        chk({tag, "_tap_out"}, 32'(tap_out), 32'd0);
        chk({tag, "_load"}, 32'(ld), 32'd0);
        chk({tag, "_move"}, 32'(mv), 32'd0);
        chk({tag, "_direction"}, 32'(dir), 32'd0);
        chk({tag, "_clear_flags"}, 32'(clr), 32'd0);
    endtask

    task automatic set_windows(input int lo0, input int hi0, input int lo1, input int hi1,
                               input int oor0);
        win_lo[0] = lo0; win_hi[0] = hi0;
        win_lo[1] = lo1; win_hi[1] = hi1;
        oor_at[0] = oor0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=0 expected=1");
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic run_case(input int lo0, input int hi0, input int lo1, input int hi1,
                            input int oor0, input exp_t e, input bit poke);
        set_windows(lo0, hi0, lo1, hi1, oor0);
        exp_q.push_back(e);
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("done_cleared_on_start", 32'(done), 32'd0);
        if (poke) begin
            repeat (100) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        wait_done();
    endtask

    initial begin
        exp_t e;
        int   seen;
        int   n;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        arst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Bit0 window 10..20 -> centre 15 after 6 decrements from tap 21; bit1 0..5 -> 2.
        e = '{loads: 8'd2, dec0: 8'd6, err: 2'b00, tap: {7'd2, 7'd15}};
        run_case(10, 20, 0, 5, 127, e, 1'b1);

        // Bit0 never passes: error, reloaded, tap 0; bit1 still trained.
        e = '{loads: 8'd3, dec0: 8'd0, err: 2'b01, tap: {7'd2, 7'd0}};
        run_case(1, 0, 0, 5, 127, e, 1'b0);

        // Bit0 window 10..12 is too narrow.
        e = '{loads: 8'd3, dec0: 8'd0, err: 2'b01, tap: {7'd2, 7'd0}};
        run_case(10, 12, 0, 5, 127, e, 1'b0);

        // Bit0 window 20..31, delay line runs out at 25 -> right 24, centre 22.
        e = '{loads: 8'd2, dec0: 8'd2, err: 2'b00, tap: {7'd2, 7'd22}};
        run_case(20, 31, 0, 5, 25, e, 1'b0);

        // Reset during bit1 sampling, then a clean rerun.
        set_windows(10, 20, 0, 5, 127);
        pulse_start();
        seen = 0;
        n = 0;
        while (seen < 2 && n < 5000) begin
            @(posedge clk); #1;
            if (clr[1]) seen++;
            n++;
        end
        chk("bit1_second_clear_seen", 32'(seen), 32'd2);
        @(posedge clk); #1;
        arst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        @(posedge clk); #1;
        arst_n = 1'b1;
        repeat (2) @(posedge clk);
        e = '{loads: 8'd2, dec0: 8'd6, err: 2'b00, tap: {7'd2, 7'd15}};
        run_case(10, 20, 0, 5, 127, e, 1'b0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
